// File: rtl/raw_bayer_pkg.sv
// Shared definitions for the raw Bayer receiver.
//   rx_state_e : frame-lock FSM states
//   TUSER_*    : bit positions inside m_tuser
//   CNT_W      : width of the pixel/line counters
package raw_bayer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE
    } rx_state_e;

    localparam int unsigned TUSER_SOF = 0;
    localparam int unsigned TUSER_ROW = 1;
    localparam int unsigned TUSER_COL = 2;

    localparam int unsigned CNT_W = 12;

endpackage

// File: rtl/raw_stream_fifo.sv
// Synchronous FIFO with a registered output stage.
//   iclk, rst_n   : clock, asynchronous active-low reset (flushes contents)
//   wr_en_i       : write request; accepted only when wr_accept_o is high
//   wr_data_i     : write payload
//   wr_accept_o   : write will be taken this cycle
//   full_o        : DEPTH entries held (memory plus output register)
//   empty_o       : nothing held
//   rd_data_o     : registered head of queue
//   rd_valid_o    : rd_data_o holds a valid entry
//   rd_ready_i    : consumer accepts rd_data_o
module raw_stream_fifo #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 64
) (
    input  logic          iclk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_accept_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o,
    input  logic          rd_ready_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   mem_cnt_q, mem_cnt_d;
    logic [AW:0]   occ;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          pop, load, wr;

    // Capacity counts the output register, so DEPTH entries total are held.
    assign occ         = mem_cnt_q + {{AW{1'b0}}, out_valid_q};
    assign full_o      = (occ == DEPTH_C);
    assign empty_o     = (occ == '0);
    assign pop         = out_valid_q & rd_ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
    assign wr_accept_o = ~full_o | pop;
    assign wr          = wr_en_i & wr_accept_o;
    assign load        = (mem_cnt_q != '0) & (~out_valid_q | pop);
    assign mem_cnt_d   = mem_cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, load};

    assign rd_data_o  = out_data_q;
    assign rd_valid_o = out_valid_q;

    always_ff @(posedge iclk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (load) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                out_data_q  <= mem_q[rd_ptr_q];
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/raw_bayer_rx.sv
// Raw RGGB camera receiver: locks onto frame sync, tags pixels with SOF,
// row/column parity and end-of-line, checks frame geometry and buffers the
// stream into a backpressurable output.
//   iclk, rst_n        : pixel clock, asynchronous active-low reset
//   sync_in            : frame sync pulse (multi-cycle)
//   line_valid_in      : active-pixel qualifier
//   data_in            : raw pixel
//   err_clr            : clears frame_err / overflow
//   m_tdata/tvalid/tready/tuser/tlast : output stream, tuser = {col, row, sof}
//   frame_err          : sticky geometry error
//   overflow           : sticky pixel drop
//   frame_cnt          : frames started since reset
module raw_bayer_rx
    import raw_bayer_pkg::*;
#(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned TRUEPIXEL  = 1920,
    parameter int unsigned TRUELINE   = 1080,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic             iclk,
    input  logic             rst_n,
    input  logic             sync_in,
    input  logic             line_valid_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [2:0]       m_tuser,
    output logic             m_tlast,
    output logic             frame_err,
    output logic             overflow,
    output logic [15:0]      frame_cnt
);

    localparam logic [CNT_W-1:0] TRUEPIXEL_C = CNT_W'(TRUEPIXEL);
    localparam logic [CNT_W-1:0] TRUELINE_C  = CNT_W'(TRUELINE);

    logic             sync_q, sync_qq, lv_q, lv_qq;
    logic [WIDTH-1:0] data_q;
    logic             sync_rise, line_start, line_end;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d, col_cur, row_q, row_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             frame_err_q, frame_err_d, overflow_q, overflow_d;
    logic             pix_wr, sof, geom_err;
    logic [2:0]       tuser;
    logic [WIDTH+3:0] wr_payload, rd_payload;
    logic             fifo_wr_accept, fifo_full, fifo_empty;
    logic             unused_fifo_flags;

    // Edges are judged on the registered stage; the live line_valid_in is the
    // successor sample of data_q, which tells us data_q ends the line.
    assign sync_rise  = sync_q & ~sync_qq;
    assign line_start = lv_q & ~lv_qq;
    assign line_end   = lv_q & ~line_valid_in;

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 1'b0;
            sync_qq <= 1'b0;
            lv_q    <= 1'b0;
            lv_qq   <= 1'b0;
            data_q  <= '0;
        end else begin
            sync_q  <= sync_in;
            sync_qq <= sync_q;
            lv_q    <= line_valid_in;
            lv_qq   <= lv_q;
            data_q  <= data_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        col_cur     = col_q;
        row_d       = row_q;
        frame_cnt_d = frame_cnt_q;
        pix_wr      = 1'b0;
        sof         = 1'b0;
        geom_err    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sync_rise) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // Sync with no line in between: empty frame.
                if (sync_rise) begin
                    geom_err = 1'b1;
                end else if (line_start) begin
                    state_d     = ACTIVE;
                    pix_wr      = 1'b1;
                    sof         = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            ACTIVE: begin
                pix_wr = lv_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pix_wr) begin
            if (line_start) begin
                col_cur = '0;
            end
            col_d = col_cur + 1'b1;
            if (line_end) begin
                row_d = row_q + 1'b1;
                if (col_d != TRUEPIXEL_C) begin
                    geom_err = 1'b1;
                end
            end
        end

        // Frame close; row_d already includes a line ending this cycle.
        if (state_q == ACTIVE && sync_rise) begin
            if (row_d != TRUELINE_C) begin
                geom_err = 1'b1;
            end
            state_d = ARMED;
            row_d   = '0;
        end
    end

    // New error events win over a coincident clear.
    assign frame_err_d = (frame_err_q & ~err_clr) | geom_err;
    assign overflow_d  = (overflow_q & ~err_clr) | (pix_wr & ~fifo_wr_accept);

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            frame_cnt_q <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            frame_cnt_q <= frame_cnt_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        tuser            = '0;
        tuser[TUSER_SOF] = sof;
        tuser[TUSER_ROW] = row_q[0];
        tuser[TUSER_COL] = col_cur[0];
    end

    assign wr_payload = {data_q, tuser, line_end};

    raw_stream_fifo #(
        .DW    (WIDTH + 4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iclk        (iclk),
        .rst_n       (rst_n),
        .wr_en_i     (pix_wr),
        .wr_data_i   (wr_payload),
        .wr_accept_o (fifo_wr_accept),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .rd_data_o   (rd_payload),
        .rd_valid_o  (m_tvalid),
        .rd_ready_i  (m_tready)
    );

    assign unused_fifo_flags = fifo_full ^ fifo_empty;

    assign m_tdata   = rd_payload[WIDTH+3:4];
    assign m_tuser   = rd_payload[3:1];
    assign m_tlast   = rd_payload[0];
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_raw_bayer_rx.sv
module tb_raw_bayer_rx;

    localparam int unsigned W  = 12;
    localparam int unsigned TP = 8;
    localparam int unsigned TL = 4;
    localparam int unsigned FD = 16;

    logic          iclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sync_in = 1'b0;
    logic          line_valid_in = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          err_clr = 1'b0;
    logic          m_tready = 1'b1;
    logic [W-1:0]  m_tdata;
    logic          m_tvalid;
    logic [2:0]    m_tuser;
    logic          m_tlast;
    logic          frame_err;
    logic          overflow;
    logic [15:0]   frame_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [W+3:0] cap_q[$];

    raw_bayer_rx #(
        .WIDTH      (W),
        .TRUEPIXEL  (TP),
        .TRUELINE   (TL),
        .FIFO_DEPTH (FD)
    ) dut (
        .iclk          (iclk),
        .rst_n         (rst_n),
        .sync_in       (sync_in),
        .line_valid_in (line_valid_in),
        .data_in       (data_in),
        .err_clr       (err_clr),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tuser       (m_tuser),
        .m_tlast       (m_tlast),
        .frame_err     (frame_err),
        .overflow      (overflow),
        .frame_cnt     (frame_cnt)
    );

    always #5 iclk = ~iclk;

    // Inputs change 1 time unit after posedge, so a beat seen here is taken
    // at the following posedge.
    always @(negedge iclk) begin
        if (rst_n && m_tvalid && m_tready) begin
            cap_q.push_back({m_tdata, m_tuser, m_tlast});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic send_line(input logic [W-1:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            line_valid_in = 1'b1;
            data_in       = base + W'(i);
            tick(1);
        end
        line_valid_in = 1'b0;
        data_in       = '0;
        tick(3);
    endtask

    task automatic send_sync();
        sync_in = 1'b1;
        tick(3);
        sync_in = 1'b0;
        tick(3);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
    endtask

    // Expected beat: {data, col parity, row parity, sof, tlast}
    function automatic logic [W+3:0] beat(input logic [W-1:0] d, input int row, input int col,
                                          input bit sof, input bit last);
        logic [31:0] r, c;
        r = row;
        c = col;
        return {d, c[0], r[0], sof, last};
    endfunction

    task automatic test_reset();
        tick(3);
        n_vec++;
        if ({m_tvalid, m_tdata, m_tuser, m_tlast} !== '0) begin
            n_err++;
            $display("FAIL reset_stream: got %0h want 0", {m_tvalid, m_tdata, m_tuser, m_tlast});
        end
        n_vec++;
        if ({frame_err, overflow, frame_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_status: got %0h want 0", {frame_err, overflow, frame_cnt});
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_pre_sync();
        send_line(12'h0F0, 8);
        tick(6);
        n_vec++;
        if (cap_q.size() != 0) begin
            n_err++;
            $display("FAIL pre_sync_beats: got %0d want 0", cap_q.size());
        end
    endtask

    task automatic test_clean_frame();
        cap_q.delete();
        send_sync();
        for (int l = 0; l < 4; l++) send_line(W'(8 * l), 8);
        tick(8);
        n_vec++;
        if (cap_q.size() != 32) begin
            n_err++;
            $display("FAIL clean_count: got %0d want 32", cap_q.size());
        end
        for (int i = 0; i < 32; i++) begin
            n_vec++;
            if (cap_q[i] !== beat(W'(i), i / 8, i % 8, i == 0, (i % 8) == 7)) begin
                n_err++;
                $display("FAIL clean_beat%0d: got %0h want %0h", i, cap_q[i],
                         beat(W'(i), i / 8, i % 8, i == 0, (i % 8) == 7));
            end
        end
        n_vec++;
        if (frame_err !== 1'b0 || frame_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL clean_status: got err=%b cnt=%0d want err=0 cnt=1", frame_err, frame_cnt);
        end
    endtask

    task automatic test_short_line();
        send_sync();
        n_vec++;
        if (frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL close_clean_err: got %b want 0", frame_err);
        end
        cap_q.delete();
        send_line(12'h100, 8);
        n_vec++;
        if (frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL short_pre_err: got %b want 0", frame_err);
        end
        send_line(12'h108, 7);
        n_vec++;
        if (frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL short_err: got %b want 1", frame_err);
        end
        send_line(12'h10F, 8);
        send_line(12'h117, 8);
        tick(8);
        n_vec++;
        if (cap_q.size() != 31) begin
            n_err++;
            $display("FAIL short_count: got %0d want 31", cap_q.size());
        end
        n_vec++;
        if (cap_q[0] !== beat(12'h100, 0, 0, 1'b1, 1'b0)) begin
            n_err++;
            $display("FAIL short_sof: got %0h want %0h", cap_q[0], beat(12'h100, 0, 0, 1'b1, 1'b0));
        end
        n_vec++;
        if (cap_q[14] !== beat(12'h10E, 1, 6, 1'b0, 1'b1)) begin
            n_err++;
            $display("FAIL short_tlast: got %0h want %0h", cap_q[14],
                     beat(12'h10E, 1, 6, 1'b0, 1'b1));
        end
        n_vec++;
        if (cap_q[15] !== beat(12'h10F, 2, 0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL short_next: got %0h want %0h", cap_q[15],
                     beat(12'h10F, 2, 0, 1'b0, 1'b0));
        end
        pulse_clr();
        n_vec++;
        if (frame_err !== 1'b0 || frame_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL short_clr: got err=%b cnt=%0d want err=0 cnt=2", frame_err, frame_cnt);
        end
    endtask

    task automatic test_short_frame();
        cap_q.delete();
        send_sync();
        for (int l = 0; l < 3; l++) send_line(12'h200 + W'(8 * l), 8);
        n_vec++;
        if (frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL sframe_pre_err: got %b want 0", frame_err);
        end
        send_sync();
        n_vec++;
        if (frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL sframe_err: got %b want 1", frame_err);
        end
        for (int l = 0; l < 4; l++) send_line(12'h300 + W'(8 * l), 8);
        tick(8);
        n_vec++;
        if (cap_q.size() != 56) begin
            n_err++;
            $display("FAIL sframe_count: got %0d want 56", cap_q.size());
        end
        n_vec++;
        if (cap_q[24] !== beat(12'h300, 0, 0, 1'b1, 1'b0)) begin
            n_err++;
            $display("FAIL sframe_sof: got %0h want %0h", cap_q[24], beat(12'h300, 0, 0, 1'b1, 1'b0));
        end
        n_vec++;
        if (cap_q[55] !== beat(12'h31F, 3, 7, 1'b0, 1'b1)) begin
            n_err++;
            $display("FAIL sframe_last: got %0h want %0h", cap_q[55],
                     beat(12'h31F, 3, 7, 1'b0, 1'b1));
        end
        n_vec++;
        if (frame_err !== 1'b1 || frame_cnt !== 16'd4) begin
            n_err++;
            $display("FAIL sframe_status: got err=%b cnt=%0d want err=1 cnt=4", frame_err, frame_cnt);
        end
        pulse_clr();
    endtask

    task automatic test_overflow();
        cap_q.delete();
        m_tready = 1'b0;
        send_sync();
        for (int l = 0; l < 4; l++) send_line(12'h400 + W'(8 * l), 8);
        tick(4);
        n_vec++;
        if (overflow !== 1'b1 || m_tvalid !== 1'b1 || m_tdata !== 12'h400) begin
            n_err++;
            $display("FAIL ovf_stall: got ovf=%b vld=%b data=%0h want ovf=1 vld=1 data=400",
                     overflow, m_tvalid, m_tdata);
        end
        n_vec++;
        if (cap_q.size() != 0) begin
            n_err++;
            $display("FAIL ovf_stall_beats: got %0d want 0", cap_q.size());
        end
        m_tready = 1'b1;
        tick(30);
        n_vec++;
        if (cap_q.size() != 16) begin
            n_err++;
            $display("FAIL ovf_count: got %0d want 16", cap_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (cap_q[i] !== beat(12'h400 + W'(i), i / 8, i % 8, i == 0, (i % 8) == 7)) begin
                n_err++;
                $display("FAIL ovf_beat%0d: got %0h want %0h", i, cap_q[i],
                         beat(12'h400 + W'(i), i / 8, i % 8, i == 0, (i % 8) == 7));
            end
        end
        pulse_clr();
        n_vec++;
        if (overflow !== 1'b0 || m_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clr: got ovf=%b vld=%b want 0 0", overflow, m_tvalid);
        end
    endtask

    task automatic test_reset_mid();
        send_sync();
        send_line(12'h500, 8);
        for (int i = 0; i < 3; i++) begin
            line_valid_in = 1'b1;
            data_in       = 12'h508 + W'(i);
            tick(1);
        end
        rst_n         = 1'b0;
        line_valid_in = 1'b0;
        data_in       = '0;
        tick(3);
        n_vec++;
        if ({m_tvalid, m_tdata, m_tuser, m_tlast, frame_err, overflow, frame_cnt} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %0h want 0",
                     {m_tvalid, m_tdata, m_tuser, m_tlast, frame_err, overflow, frame_cnt});
        end
        rst_n = 1'b1;
        cap_q.delete();
        tick(2);
        send_line(12'h600, 8);
        tick(6);
        n_vec++;
        if (cap_q.size() != 0) begin
            n_err++;
            $display("FAIL mid_no_sync_beats: got %0d want 0", cap_q.size());
        end
        send_sync();
        for (int l = 0; l < 4; l++) send_line(12'h700 + W'(8 * l), 8);
        tick(8);
        n_vec++;
        if (cap_q.size() != 32) begin
            n_err++;
            $display("FAIL mid_count: got %0d want 32", cap_q.size());
        end
        n_vec++;
        if (cap_q[0] !== beat(12'h700, 0, 0, 1'b1, 1'b0)) begin
            n_err++;
            $display("FAIL mid_sof: got %0h want %0h", cap_q[0], beat(12'h700, 0, 0, 1'b1, 1'b0));
        end
        n_vec++;
        if (cap_q[31] !== beat(12'h71F, 3, 7, 1'b0, 1'b1)) begin
            n_err++;
            $display("FAIL mid_last: got %0h want %0h", cap_q[31], beat(12'h71F, 3, 7, 1'b0, 1'b1));
        end
        n_vec++;
        if (frame_cnt !== 16'd1 || frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL mid_status: got cnt=%0d err=%b want cnt=1 err=0", frame_cnt, frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_pre_sync();
        test_clean_frame();
        test_short_line();
        test_short_frame();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/raw_bayer_rx.md
# raw_bayer_rx

Receiver stage directly downstream of the raw RGGB camera source. It takes the source's frame sync, line-valid and 12-bit pixel stream and locks onto frame boundaries. It tags every pixel with start-of-frame, end-of-line and Bayer phase, checks frame geometry, and buffers the result into a backpressurable stream for the debayer/ISP pipeline. The source cannot be stalled, so the block absorbs downstream backpressure in a FIFO and reports overflow.

## Interface
- WIDTH, 12, pixel width
- TRUEPIXEL, 1920, expected active pixels per line
- TRUELINE, 1080, expected active lines per frame
- FIFO_DEPTH, 64, output buffer depth in pixels (power of two, ≥4)

Ports:
- iclk  in  1  pixel clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- sync_in  in  1  frame sync pulse (multi-cycle high) from the source
- line_valid_in  in  1  high during active pixels of a line
- data_in  in  WIDTH  raw Bayer pixel, valid when line_valid_in=1
- err_clr  in  1  one-cycle pulse; clears sticky status bits
- m_tdata  out  WIDTH  pixel
- m_tvalid  out  1  output pixel valid
- m_tready  in  1  downstream accept
- m_tuser  out  3  [0]=SOF (first pixel of frame), [1]=row parity, [2]=column parity
- m_tlast  out  1  last pixel of a line
- frame_err  out  1  sticky: a line length ≠ TRUEPIXEL or line count ≠ TRUELINE
- overflow  out  1  sticky: pixel dropped because FIFO full
- frame_cnt  out  16  frames started since reset, wraps at 2^16

## Operation
- Input stage: sync_in, line_valid_in and data_in are registered once. The registered pixel sees the next line_valid_in, so EOL is known when the pixel is written.
- FSM states:
  - IDLE: reset state. Pixels are discarded. A sync_in rising edge goes to ARMED.
  - ARMED: waiting for the first line. The first line_valid_in rising edge goes to ACTIVE. That line's first pixel carries SOF, row=0.
  - ACTIVE: counts pixels and lines.
    - Line counter increments at each line_valid_in falling edge.
    - A sync_in rising edge closes the frame: line count is compared against TRUELINE, then the state goes to ARMED.
- A sync_in rising edge in ARMED (a frame with no lines) stays in ARMED and sets frame_err.
- frame_cnt increments on each ARMED→ACTIVE transition.
- Column counter resets at each line start.
- Row parity and column parity are counter bit 0.
- m_tlast is set on the pixel whose successor sample has line_valid_in=0, regardless of line length.
- Line-length check: at line end, a column count ≠ TRUEPIXEL sets frame_err. Lines longer than TRUEPIXEL are passed through, not truncated.
- FIFO write: every active pixel in ACTIVE state is written.
  - If the FIFO is full, the pixel is dropped and overflow is set.
  - A dropped EOL or SOF pixel is not re-tagged onto a neighbour.
- err_clr clears frame_err and overflow. If err_clr coincides with a new error event, the error wins (bit stays 1).

## Timing
- Reset values: all outputs 0, FSM=IDLE, FIFO empty, counters 0.
- Latency: pixel sampled at edge N → m_tvalid=1 with that pixel after edge N+2, provided the FIFO was empty. The path is input register, FIFO write, registered FIFO output.
- m_tdata, m_tuser and m_tlast are held stable while m_tvalid=1 && m_tready=0.
- FIFO full/empty: simultaneous read and write when full is allowed. The read frees a slot in the same cycle, so no drop occurs.
- Counters are WIDTH-independent, 12 bits each; wrap is undefined beyond 4095 and is not checked.
- Reset asserted mid-frame: the FIFO is flushed, and the block returns to IDLE and waits for the next sync rising edge. No partial frame is emitted after release.

## Structure
- Shared package raw_bayer_pkg holds:
  - the FSM state enum {IDLE, ARMED, ACTIVE}
  - tuser bit-index constants TUSER_SOF=0, TUSER_ROW=1, TUSER_COL=2
- Sub-module raw_stream_fifo: synchronous FIFO with registered output.
  - Payload is WIDTH+4 bits (data, tuser, tlast).
  - Provides full, empty and write-accept.
- Everything else lives in raw_bayer_rx.

## Test plan
Bench parameters: TRUEPIXEL=8, TRUELINE=4, FIFO_DEPTH=16.
- Clean frame with m_tready=1: sync pulse, then 4 lines of 8 pixels with values 0..31.
  - Expect 32 beats in order.
  - SOF only on value 0; tlast on 7, 15, 23, 31; tuser parities follow (row, col).
  - frame_err=0, frame_cnt=1.
- Pixels before the first sync → none output.
  - The first-sync frame then behaves as the clean-frame case.
- Short line (7 pixels) in line 2 → tlast on its 7th pixel and frame_err=1 at line end.
  - err_clr then returns frame_err to 0.
- Frame of 3 lines followed by sync → frame_err=1 at the sync rising edge.
  - The next frame's first pixel still has SOF and frame_cnt increments.
- m_tready=0 for a whole 32-pixel frame → first 16 pixels retained, remaining 16 dropped, overflow=1.
  - After m_tready=1, exactly 16 beats emerge, in order.
- rst_n low mid-line 2 for 3 cycles → outputs 0 and FIFO empty.
  - After release, no output until the next sync; the next frame is emitted complete with SOF.
